cayde_fetch: RTL and testbench

Instruction fetch unit for the cayde RISC-V core. It is the producer side of the instruction word that the decoder consumes. It owns the PC and issues word requests to instruction memory over a valid/ready request channel. In-order responses are buffered in a small FIFO and presented to the decoder with a valid/ready handshake. Branch/jump redirects flush the buffer and discard stale in-flight responses.

---
 rtl/cayde_pkg.sv | 27 ++
 rtl/cayde_fetch_fifo.sv | 76 +++++++
 rtl/cayde_fetch.sv | 133 +++++++++++++
 tb/tb_cayde_fetch.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cayde_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cayde_pkg
//  Description : Shared types and constants for the cayde instruction fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
package cayde_pkg;

    typedef enum logic [0:0] {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cayde_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cayde_fetch_fifo
//  Description : Synchronous FIFO of fetch entries with flush and occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module cayde_fetch_fifo
    import cayde_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  fetch_entry_t               entry_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q,  count_d;
    logic           do_pop;

    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    assign do_pop  = pop_i && valid_o;
    // Empty slots read as zero so the consumer never sees stale contents.
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cayde_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : cayde_fetch
//  Description : Instruction fetch unit: PC, credit-limited memory requests,
//                in-order response buffer, redirect flush and error halt.
//  Revision    : 1.0 - initial release
// ============================================================================
module cayde_fetch
    import cayde_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_err
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

    fetch_state_e   state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    tag_q, tag_d;
    logic [CW-1:0]  outst_q, outst_d;
    logic [CW-1:0]  discard_q, discard_d;

    logic [CW-1:0]  fifo_count;
    logic           fifo_valid;
    fetch_entry_t   fifo_head;
    fetch_entry_t   push_entry;

    logic           credit_ok;
    logic           req_fire;
    logic           rsp_drop;
    logic           rsp_push;
    logic           instr_fire;
    logic [31:0]    redirect_al;

    // Buffered plus in-flight words never exceed the buffer size, so every
    // accepted request already owns a slot. Independent of redirect_valid.
    assign credit_ok      = ({1'b0, outst_q} + {1'b0, fifo_count}) < DEPTH_C;
    assign imem_req_valid = rst_n && (state_q == FETCH_RUN) && credit_ok;
    assign imem_req_addr  = rst_n ? word_align(pc_q) : '0;

    assign req_fire    = imem_req_valid && imem_req_ready;
    assign rsp_drop    = imem_rsp_valid && (discard_q != '0);
    assign rsp_push    = imem_rsp_valid && !rsp_drop && !redirect_valid;
    assign instr_fire  = instr_valid && instr_ready && !redirect_valid;
    assign redirect_al = word_align(redirect_pc);

    assign outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);

    always_comb begin
        push_entry.instr = imem_rsp_data;
        push_entry.pc    = tag_q;
        push_entry.err   = imem_rsp_err;
    end

    always_comb begin
        pc_d      = pc_q;
        tag_d     = tag_q;
        state_d   = state_q;
        discard_d = discard_q - CW'(rsp_drop);
        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old
            // path, including a request accepted in this very cycle.
            pc_d      = redirect_al;
            tag_d     = redirect_al;
            state_d   = FETCH_RUN;
            discard_d = outst_d;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (rsp_push) begin
                tag_d = tag_q + 32'd4;
                if (imem_rsp_err) begin
                    state_d = FETCH_HALT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH_RUN;
            pc_q      <= word_align(RESET_PC);
            tag_q     <= word_align(RESET_PC);
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tag_q     <= tag_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    cayde_fetch_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rsp_push),
        .entry_i (push_entry),
        .pop_i   (instr_fire),
        .flush_i (redirect_valid),
        .head_o  (fifo_head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign instr_valid = fifo_valid;
    assign instr_out   = fifo_head.instr;
    assign instr_pc    = fifo_head.pc;
    assign instr_err   = fifo_head.err;

endmodule
`default_nettype wire

// File: tb/tb_cayde_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cayde_fetch
//  Description : Scoreboard bench for cayde_fetch with a program-order model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cayde_fetch;
    import cayde_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid, imem_rsp_err;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready, instr_err;
    logic [31:0] instr_out, instr_pc;

    logic        w_req_valid, w_rsp_valid, w_instr_valid, w_instr_err;
    logic [31:0] w_req_addr, w_rsp_data, w_instr_out, w_instr_pc;
    logic        w_one = 1'b1;
    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = 32'h0;

    cayde_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_err(instr_err)
    );

    cayde_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_one),
        .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .imem_rsp_err(w_zero),
        .redirect_valid(w_zero), .redirect_pc(w_zero32),
        .instr_valid(w_instr_valid), .instr_ready(w_one),
        .instr_out(w_instr_out), .instr_pc(w_instr_pc), .instr_err(w_instr_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] data; logic err; } exp_t;
    typedef struct { logic [31:0] addr; int due; int epoch; } mem_t;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    int          total = 0, bad = 0, cyc = 0, epoch = 0;
    logic [31:0] gen_pc = 32'h0;
    bit          model_halted = 1'b0;
    logic [31:0] salt = 32'h0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          ready_pct = 100, dec_pct = 100, lat_min = 1, lat_max = 1, redir_pct = 0;
    bit          cur_rsp_valid = 1'b0, cur_rsp_err = 1'b0;
    int          cur_rsp_epoch = 0;
    int          acc_count = 0, pop_count = 0, wrap_idx = 0;
    int          first_acc_cyc = -1, first_val_cyc = -1;
    bit          prev_stall = 1'b0, prev_redir = 1'b0, want_first = 1'b0;
    logic [31:0] prev_addr = 32'h0, first_pop_pc = 32'h0, err_pop_pc = 32'h0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ salt;
    endfunction

    function automatic logic errfn(input logic [31:0] a);
        return (a == err_addr);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Trivial one-cycle memory for the wrap-around instance: data = address.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_rsp_valid <= 1'b0;
            w_rsp_data  <= 32'h0;
        end else begin
            w_rsp_valid <= w_req_valid;
            w_rsp_data  <= w_req_addr;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            wrap_idx = 0;
        end else if (w_req_valid && wrap_idx < 4) begin
            check("wrap_addr", w_req_addr, 32'hFFFF_FFF8 + 32'(4 * wrap_idx));
            wrap_idx++;
        end
    end

    // Monitor: whatever the decoder sees must be the head of the program-order stream.
    always @(negedge clk) begin
        if (rst_n && instr_valid) begin
            if (first_val_cyc < 0) first_val_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr: got pc %h data %h, expected nothing", instr_pc, instr_out);
            end else begin
                check("instr_pc", instr_pc, exp_q[0].pc);
                check("instr_out", instr_out, exp_q[0].data);
                check("instr_err", 32'(instr_err), 32'(exp_q[0].err));
                if (instr_ready && !redirect_valid) begin
                    if (want_first) begin
                        first_pop_pc = instr_pc;
                        want_first   = 1'b0;
                    end
                    if (instr_err) err_pop_pc = instr_pc;
                    pop_count++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Request tracker: feeds the scoreboard and the memory model.
    always @(negedge clk) begin
        int due;
        #1;
        if (rst_n) begin
            if (prev_stall && !model_halted) begin
                check("req_hold_valid", 32'(imem_req_valid), 32'h1);
                if (!prev_redir) check("req_hold_addr", imem_req_addr, prev_addr);
            end
            if (imem_req_valid && imem_req_ready) begin
                acc_count++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                due = cyc + $urandom_range(lat_min, lat_max);
                if (mem_q.size() > 0 && due <= mem_q[$].due) due = mem_q[$].due + 1;
                mem_q.push_back('{addr: imem_req_addr, due: due, epoch: epoch});
                if (!redirect_valid) begin
                    check("req_addr", imem_req_addr, gen_pc);
                    check("req_while_halted", 32'(model_halted), 32'h0);
                    exp_q.push_back('{pc: gen_pc, data: memfn(gen_pc), err: errfn(gen_pc)});
                    gen_pc = gen_pc + 32'd4;
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                gen_pc       = {redirect_pc[31:2], 2'b00};
                epoch++;
                model_halted = 1'b0;
            end else if (cur_rsp_valid && cur_rsp_err && cur_rsp_epoch == epoch) begin
                model_halted = 1'b1;
            end
            prev_stall = imem_req_valid && !imem_req_ready;
            prev_addr  = imem_req_addr;
            prev_redir = redirect_valid;
        end
    end

    task automatic step(input bit force_redir = 1'b0, input logic [31:0] rpc = 32'h0);
        mem_t m;
        @(posedge clk);
        #1;
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        instr_ready    = ($urandom_range(0, 99) < dec_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m              = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(m.addr);
            imem_rsp_err   = errfn(m.addr);
            cur_rsp_valid  = 1'b1;
            cur_rsp_err    = errfn(m.addr);
            cur_rsp_epoch  = m.epoch;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = INSTR_NOP;
            imem_rsp_err   = 1'b0;
            cur_rsp_valid  = 1'b0;
            cur_rsp_err    = 1'b0;
        end
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = rpc;
        end else if (redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
            redirect_valid = 1'b1;
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                         : ($urandom & 32'h0000_00FF);
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mem_q.delete();
        gen_pc        = 32'h0;
        model_halted  = 1'b0;
        epoch++;
        prev_stall    = 1'b0;
        prev_redir    = 1'b0;
        cur_rsp_valid = 1'b0;
        cur_rsp_err   = 1'b0;
        acc_count     = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = INSTR_NOP;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        check({tag, "_req_addr"}, imem_req_addr, 32'h0);
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
        check({tag, "_instr_out"}, instr_out, 32'h0);
        check({tag, "_instr_pc"}, instr_pc, 32'h0);
        check({tag, "_instr_err"}, 32'(instr_err), 32'h0);
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = INSTR_NOP;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("rst");
        check("rst_wrap_addr", w_req_addr, 32'h0);

        // Streaming fetch, one-cycle memory returning the address as data.
        step();
        rst_n = 1'b1;
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'h1);
        check("first_req_addr", imem_req_addr, 32'h0);
        repeat (8) step();
        check("fill_latency", 32'(first_val_cyc - first_acc_cyc), 32'd2);
        check("stream_accepts", 32'(acc_count >= 4), 32'h1);

        // Fill the buffer, then reset asynchronously mid-stream.
        dec_pct = 0;
        repeat (6) step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        model_reset();
        salt = 32'h5A5A_F00F;
        repeat (2) @(posedge clk);

        // Decoder stalled for ten cycles after reset release.
        dec_pct = 0;
        step();
        rst_n = 1'b1;
        #1;
        check("rel_req_valid", 32'(imem_req_valid), 32'h1);
        check("rel_req_addr", imem_req_addr, 32'h0);
        repeat (9) step();
        check("bp_accepts", 32'(acc_count), 32'd2);
        check("bp_req_valid", 32'(imem_req_valid), 32'h0);
        check("bp_head_pc", instr_pc, 32'h0);
        dec_pct = 100;
        repeat (8) step();

        // Redirect with two responses in flight on a three-cycle memory.
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 50 && mem_q.size() < 2; i++) step();
        check("two_outstanding", 32'(mem_q.size()), 32'd2);
        want_first = 1'b1;
        step(1'b1, 32'h0000_0100);
        repeat (14) step();
        check("redir_first_pc", first_pop_pc, 32'h0000_0100);

        // Bus error at address 8 halts fetch until the next redirect.
        lat_min  = 1;
        lat_max  = 1;
        err_addr = 32'h0000_0008;
        step(1'b1, 32'h0000_0000);
        for (int i = 0; i < 40 && !model_halted; i++) step();
        check("halted", 32'(model_halted), 32'h1);
        repeat (8) step();
        check("halt_req_valid", 32'(imem_req_valid), 32'h0);
        check("err_pc", err_pop_pc, 32'h0000_0008);
        err_addr   = 32'hFFFF_FFFF;
        want_first = 1'b1;
        step(1'b1, 32'h0000_0042);
        repeat (10) step();
        check("restart_pc", first_pop_pc, 32'h0000_0040);

        // Randomised traffic with redirects, errors and backpressure.
        err_addr  = 32'h0000_0030;
        redir_pct = 3;
        lat_min   = 1;
        lat_max   = 4;
        for (int blk = 0; blk < 15; blk++) begin
            ready_pct = $urandom_range(30, 100);
            dec_pct   = $urandom_range(30, 100);
            repeat (200) step();
        end
        redir_pct = 0;
        ready_pct = 100;
        dec_pct   = 100;
        step(1'b1, 32'h0000_0200);
        repeat (20) step();
        check("progress", 32'(pop_count > 500), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
